srt4_digit_iter: RTL and testbench

SRT4_DIGIT_ITER -- requirements
Module: srt4_digit_iter

---
 rtl/srt4_digit_iter.sv | 150 +++++++++++++++
 tb/tb_srt4_digit_iter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/srt4_digit_iter.sv
// srt4_digit_iter
//   Radix-4 SRT division digit iterator. Accepts a 32-bit unsigned dividend x
//   and a normalized divisor d (bit 31 set). It emits 16 signed quotient
//   digits in {-2..+2}, one per un-stalled cycle, and then presents the final
//   partial remainder W16 for one cycle. The following identity holds:
//     x * 2^32 = 4*Q*d + W16,  Q = sum q_i * 4^(16-i)
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a division (honoured only when idle)
//   dividend   x, sampled on an accepted start
//   divisor    d, sampled on an accepted start
//   stall      downstream back-pressure; freezes the iteration
//   q_digit    digit code: 010 +2, 001 +1, 000 0, 101 -1, 110 -2
//   state_out  00 idle, 01 digit valid, 10 hold / done
//   busy       high while iterating (run or hold)
//   done       one-cycle pulse after the last digit
//   rem_out    final partial remainder (valid while done)
//   rem_neg    sign of the raw W16 (valid while done)
//
// Build option
//   SRT4_REM_CORRECT_EN : when defined, rem_out is corrected into [0, 4d).
module srt4_digit_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        stall,
  output logic [2:0]  q_digit,
  output logic [1:0]  state_out,
  output logic        busy,
  output logic        done,
  output logic [35:0] rem_out,
  output logic        rem_neg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic signed [37:0] w_q, w_d;
  logic [33:0]        d4_q, d4_d;
  logic [4:0]         count_q, count_d;

  // Selection datapath; 40 bits covers 4W and W +/- 8d without overflow.
  logic signed [39:0] r;
  logic signed [39:0] d2_s, d4_s, d6_s, d8_s;
  logic signed [39:0] w_next;
  logic [2:0]         sel_code;

  always_comb begin
    r    = {w_q, 2'b00};
    d4_s = signed'({6'b0, d4_q});
    d2_s = signed'({7'b0, d4_q[33:1]});
    d6_s = d4_s + d2_s;
    d8_s = signed'({5'b0, d4_q, 1'b0});
    if (r >= d6_s) begin
      sel_code = 3'b010;
      w_next   = r - d8_s;
    end else if (r >= d2_s) begin
      sel_code = 3'b001;
      w_next   = r - d4_s;
    end else if (r >= -d2_s) begin
      sel_code = 3'b000;
      w_next   = r;
    end else if (r >= -d6_s) begin
      sel_code = 3'b101;
      w_next   = r + d4_s;
    end else begin
      sel_code = 3'b110;
      w_next   = r + d8_s;
    end
  end

  // RUN and HOLD share one behaviour keyed on stall: a stalled cycle shows
  // 10 and parks in HOLD, an un-stalled cycle (from either state) retires a
  // digit. This way each stall cycle costs exactly one extra cycle.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    d4_d      = d4_q;
    count_d   = count_q;
    q_digit   = '0;
    state_out = 2'b00;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d     = signed'({6'b0, dividend});
          d4_d    = {divisor, 2'b00};
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN, S_HOLD: begin
        busy = 1'b1;
        if (stall) begin
          state_out = 2'b10;
          state_d   = S_HOLD;
        end else begin
          state_out = 2'b01;
          q_digit   = sel_code;
          w_d       = w_next[37:0];
          count_d   = count_q + 5'd1;
          state_d   = (count_q == 5'd15) ? S_DONE : S_RUN;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_out = 2'b10;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      d4_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      d4_q    <= d4_d;
      count_q <= count_d;
    end
  end

  // |W16| <= (8/3)d < 2^34, so the low 36 bits carry the full signed value.
`ifdef SRT4_REM_CORRECT_EN
  logic signed [37:0] w_corr;
  always_comb begin
    w_corr = w_q[37] ? (w_q + signed'({4'b0, d4_q})) : w_q;
  end
  assign rem_out = done ? w_corr[35:0] : '0;
`else
  assign rem_out = done ? w_q[35:0] : '0;
`endif
  assign rem_neg = done & w_q[37];

endmodule

// File: tb/tb_srt4_digit_iter.sv
module tb_srt4_digit_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall;
  logic [2:0]  q_digit;
  logic [1:0]  state_out;
  logic        busy;
  logic        done;
  logic [35:0] rem_out;
  logic        rem_neg;

  int total = 0;
  int bad   = 0;

  // Capture of one division, filled by run_div.
  int          dig_got [16];
  int          n_dig;
  logic [1:0]  st_log [64];
  int          done_cyc;
  logic [35:0] rem_got;
  logic        neg_got;

  srt4_digit_iter dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend),
    .divisor(divisor), .stall(stall), .q_digit(q_digit),
    .state_out(state_out), .busy(busy), .done(done),
    .rem_out(rem_out), .rem_neg(rem_neg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int decode(input logic [2:0] c);
    case (c)
      3'b010:  return 2;
      3'b001:  return 1;
      3'b000:  return 0;
      3'b101:  return -1;
      3'b110:  return -2;
      default: return 99;
    endcase
  endfunction

  // Reference: radix-4 SRT recurrence in plain integer arithmetic.
  task automatic model(input logic [31:0] x, input logic [31:0] d,
                       output int q[16], output longint w16);
    longint w, rr, dd;
    w  = longint'(x);
    dd = longint'(d);
    for (int i = 0; i < 16; i++) begin
      rr = 4 * w;
      if (rr >= 6 * dd)       q[i] = 2;
      else if (rr >= 2 * dd)  q[i] = 1;
      else if (rr >= -2 * dd) q[i] = 0;
      else if (rr >= -6 * dd) q[i] = -1;
      else                    q[i] = -2;
      w = rr - longint'(q[i]) * 4 * dd;
    end
    w16 = w;
  endtask

  function automatic longint q_value(input int q[16]);
    longint acc;
    acc = 0;
    for (int i = 0; i < 16; i++) acc = acc * 4 + longint'(q[i]);
    return acc;
  endfunction

  // Runs one division from an idle DUT; stall bit c applies to cycle c, and
  // a start pulse with other operands is injected on cycle poke (if > 0).
  task automatic run_div(input logic [31:0] x, input logic [31:0] d,
                         input logic [63:0] smask, input int poke);
    n_dig    = 0;
    done_cyc = -1;
    rem_got  = '0;
    neg_got  = 1'b0;
    dividend = x;
    divisor  = d;
    stall    = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 60; c++) begin
      stall = smask[c];
      if (c == poke) begin
        start    = 1'b1;
        dividend = ~x;
        divisor  = 32'hC000_0001;
      end else begin
        start = 1'b0;
      end
      #1;
      st_log[c] = state_out;
      if (state_out == 2'b01 && n_dig < 16) begin
        dig_got[n_dig] = decode(q_digit);
        n_dig++;
      end
      if (done) begin
        done_cyc = c;
        rem_got  = rem_out;
        neg_got  = rem_neg;
        break;
      end
      step();
    end
    start = 1'b0;
    stall = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; dividend = '0; divisor = '0;
    repeat (2) step();
    total++; if (state_out !== 2'b00) begin bad++; $display("FAIL reset_state_out got=%b exp=00", state_out); end
    total++; if (q_digit !== 3'b000) begin bad++; $display("FAIL reset_q_digit got=%b exp=000", q_digit); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (rem_out !== 36'd0 || rem_neg !== 1'b0) begin bad++; $display("FAIL reset_rem got=%h/%b exp=0/0", rem_out, rem_neg); end
    rst = 1'b0;
    step();
    total++; if (state_out !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b/%b exp=00/0", state_out, busy); end
  endtask

  task automatic test_exact_half();
    longint q;
    run_div(32'h8000_0000, 32'h8000_0000, 64'd0, 0);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (dig_got[i] !== ((i == 0) ? 1 : 0)) begin bad++; $display("FAIL s1_digit%0d got=%0d exp=%0d", i, dig_got[i], (i == 0) ? 1 : 0); end
    end
    q = q_value(dig_got);
    total++; if (q != 64'h4000_0000) begin bad++; $display("FAIL s1_q got=%h exp=40000000", q); end
    total++; if (done_cyc != 17) begin bad++; $display("FAIL s1_done_cycle got=%0d exp=17", done_cyc); end
    total++; if (rem_got !== 36'd0 || neg_got !== 1'b0) begin bad++; $display("FAIL s1_rem got=%h/%b exp=0/0", rem_got, neg_got); end
  endtask

  task automatic test_zero_dividend();
    int errs;
    errs = 0;
    run_div(32'h0, 32'hFFFF_FFFF, 64'd0, 0);
    for (int c = 1; c <= 16; c++) if (st_log[c] !== 2'b01) errs++;
    for (int i = 0; i < 16; i++) if (dig_got[i] != 0) errs++;
    total++; if (errs != 0 || n_dig != 16) begin bad++; $display("FAIL s2_digits got=%0d_errors/%0d_digits exp=0/16", errs, n_dig); end
    total++; if (rem_got !== 36'd0) begin bad++; $display("FAIL s2_rem got=%h exp=0", rem_got); end
  endtask

  task automatic test_stall();
    int errs;
    errs = 0;
    run_div(32'h8000_0000, 32'h8000_0000, 64'h38, 0);
    for (int c = 3; c <= 5; c++) begin
      total++;
      if (st_log[c] !== 2'b10) begin bad++; $display("FAIL s3_hold_cycle%0d got=%b exp=10", c, st_log[c]); end
    end
    for (int i = 0; i < 16; i++) if (dig_got[i] != ((i == 0) ? 1 : 0)) errs++;
    total++; if (errs != 0 || n_dig != 16) begin bad++; $display("FAIL s3_digits got=%0d_errors exp=0", errs); end
    total++; if (done_cyc != 20) begin bad++; $display("FAIL s3_done_cycle got=%0d exp=20", done_cyc); end
  endtask

  task automatic test_reset_mid();
    dividend = 32'h1234_5678;
    divisor  = 32'h9ABC_DEF0;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    #2 rst = 1'b1;
    #1;
    total++; if (state_out !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL s4_async_reset got=%b/%b exp=00/0", state_out, busy); end
    total++; if (q_digit !== 3'b000 || done !== 1'b0) begin bad++; $display("FAIL s4_reset_outputs got=%b/%b exp=000/0", q_digit, done); end
    step();
    rst = 1'b0;
    step();
    run_div(32'h8000_0000, 32'h8000_0000, 64'd0, 0);
    total++; if (q_value(dig_got) != 64'h4000_0000 || done_cyc != 17 || rem_got !== 36'd0)
      begin bad++; $display("FAIL s4_after_reset got=q%h/c%0d/r%h exp=40000000/17/0", q_value(dig_got), done_cyc, rem_got); end
  endtask

  task automatic test_start_ignored();
    int     q_ref[16];
    longint w_ref;
    logic [31:0] x, d;
    x = 32'hDEAD_BEEF;
    d = 32'hB504_F333;
    model(x, d, q_ref, w_ref);
    run_div(x, d, 64'd0, 5);
    total++; if (q_value(dig_got) != q_value(q_ref) || n_dig != 16)
      begin bad++; $display("FAIL s6_q got=%h exp=%h", q_value(dig_got), q_value(q_ref)); end
    total++; if (done_cyc != 17) begin bad++; $display("FAIL s6_done_cycle got=%0d exp=17", done_cyc); end
    total++; if (neg_got !== (w_ref < 0)) begin bad++; $display("FAIL s6_rem_neg got=%b exp=%b", neg_got, w_ref < 0); end
    step();
    total++; if (state_out !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL s6_back_idle got=%b/%b exp=00/0", state_out, busy); end
  endtask

  task automatic test_random();
    int          q_ref[16];
    longint      w_ref, q_dut, w_dut, w_exp_rem, flo;
    logic [31:0] x, d, rnd;
    logic [63:0] smask;
    logic [35:0] exp_rem;
    logic signed [127:0] lhs, rhs, qa, da, wa;
    int          exp_done, ndg, st_err, dig_err;
    for (int n = 0; n < 400; n++) begin
      if (n == 0)      begin x = 32'hFFFF_FFFF; d = 32'h8000_0000; end
      else if (n == 1) begin x = 32'hFFFF_FFFF; d = 32'hFFFF_FFFF; end
      else if (n == 2) begin x = 32'h0000_0001; d = 32'h8000_0001; end
      else begin
        x   = $urandom();
        rnd = $urandom();
        d   = rnd | 32'h8000_0000;
      end
      smask = '0;
      for (int b = 1; b <= 40; b++) smask[b] = ($urandom_range(99) < 15);
      model(x, d, q_ref, w_ref);
      exp_done = 1; ndg = 0;
      while (ndg < 16) begin
        if (!smask[exp_done]) ndg++;
        exp_done++;
      end
      run_div(x, d, smask, 0);

      dig_err = 0;
      for (int i = 0; i < 16; i++) if (dig_got[i] != q_ref[i]) dig_err++;
      total++; if (dig_err != 0 || n_dig != 16) begin bad++; $display("FAIL rnd_digits x=%h d=%h got=%0d_errors exp=0", x, d, dig_err); end

      st_err = 0;
      for (int c = 1; c < exp_done && c < 60; c++) if (st_log[c] !== (smask[c] ? 2'b10 : 2'b01)) st_err++;
      total++; if (st_err != 0) begin bad++; $display("FAIL rnd_state_seq x=%h d=%h got=%0d_errors exp=0", x, d, st_err); end

      total++; if (done_cyc != exp_done) begin bad++; $display("FAIL rnd_done_cycle got=%0d exp=%0d", done_cyc, exp_done); end

`ifdef SRT4_REM_CORRECT_EN
      w_exp_rem = (w_ref < 0) ? w_ref + 4 * longint'(d) : w_ref;
      w_dut     = longint'(rem_got) - (neg_got ? 4 * longint'(d) : 64'sd0);
`else
      w_exp_rem = w_ref;
      w_dut     = longint'(signed'(rem_got));
`endif
      exp_rem = w_exp_rem[35:0];
      total++; if (rem_got !== exp_rem || neg_got !== (w_ref < 0))
        begin bad++; $display("FAIL rnd_rem x=%h d=%h got=%h/%b exp=%h/%b", x, d, rem_got, neg_got, exp_rem, w_ref < 0); end

      // Division identity from the DUT's own digits and remainder.
      q_dut = q_value(dig_got);
      lhs = {64'b0, x, 32'b0};
      qa  = q_dut;
      da  = {96'b0, d};
      wa  = w_dut;
      rhs = 4 * qa * da + wa;
      total++; if (lhs != rhs) begin bad++; $display("FAIL rnd_identity x=%h d=%h got=%h exp=%h", x, d, rhs, lhs); end

      flo = longint'({2'b0, x, 30'b0} / {32'b0, d});
      total++; if (q_dut - (neg_got ? 1 : 0) != flo)
        begin bad++; $display("FAIL rnd_floor x=%h d=%h got=%0d exp=%0d", x, d, q_dut - (neg_got ? 1 : 0), flo); end
    end
  endtask

  initial begin
    test_reset();
    test_exact_half();
    test_zero_dividend();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
